return_address_stack: RTL
=========================

// Module: return_address_stack
// PURPOSE
//  Hardware call/return stack that supplies the ReturnAddress bus consumed by the PC register stage.
//  - CALL (JAL): the link address PC+4 is pushed.
//  - Return (stop bit): the top entry is popped.
//  - The top entry is always presented combinationally from registers, so the PC stage samples it on
//    the same clock edge as the pop.
//  Sits beside instruction fetch; controlled by decode (sig_push/sig_pop).
// PARAMETERS
//  DEPTH    16  number of entries; power of two, >=2
//  ADDR_W   32  width of stored return addresses
//  CNT_W     5  occupancy counter width = log2(DEPTH)+1
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       synchronous, active-high reset
//  sig_push         in   1       push PC+4 (CALL/JAL in fetch)
//  sig_pop          in   1       pop top entry (return; same cycle sig_pc_src selects RA)
//  PC               in   ADDR_W  current PC from the PC register stage
//  ReturnAddress    out  ADDR_W  top of stack; 0 when empty
//  stack_empty      out  1       occupancy == 0
//  stack_full       out  1       occupancy == DEPTH
//  occupancy        out  CNT_W   number of valid entries
//  overflow_err     out  1       sticky: push attempted while full
//  underflow_err    out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (sync, high)
//   - occupancy=0, stack_empty=1, stack_full=0, ReturnAddress=0, both error flags=0.
//   - Entry array is not cleared.
//   - Reset overrides push/pop in the same cycle, including mid-sequence.
//  Storage and top-of-stack
//   - Storage is mem[0..DEPTH-1]; stack pointer sp = occupancy; top = mem[sp-1].
//   - ReturnAddress is driven from a registered top copy top_q, with no memory read mux on the output path.
//   - Push value is PC + 32'd4, modulo 2^ADDR_W (wraps, no carry out).
//  Per-edge operations (all single cycle; effects visible the cycle after the edge)
//   - push only, not full: mem[sp] <= PC+4; sp+1; top_q <= PC+4.
//   - pop only, not empty: sp-1; top_q <= mem[sp-2] if sp>=2, else 0.
//     ReturnAddress before the edge is the popped value.
//   - push+pop, not empty: replace top. mem[sp-1] <= PC+4; top_q <= PC+4; sp unchanged.
//     ReturnAddress before the edge is still the old top, so the PC stage returns to it.
//   - push+pop, empty: treated as push. Set underflow_err.
//   - push while full (no pop): push dropped; contents unchanged; set overflow_err.
//   - push+pop while full: replace-top rule applies; no overflow.
//   - pop while empty (no push): no change; ReturnAddress stays 0; set underflow_err.
//   - neither asserted: hold all state.
//  Error flags and status
//   - Error flags are sticky until reset.
//   - stack_full and stack_empty are decoded from occupancy, which is registered.
//  Latency
//   - ReturnAddress reflects a push one cycle after the push edge.
//   - Back-to-back pushes, pops and push/pop mixes are legal every cycle; no stall output.
// STRUCTURE
//  Shared package (pc-path definitions)
//   - PC_Src_Dft/Ra/BTA/Jmp 2-bit codes.
//   - RAS_DEPTH default.
//   - link offset constant 32'd4.
//  No sub-module.
//   - Storage is an inline register array (DEPTH<=64 assumed synthesisable as flops).
//   - The pointer/flag logic stays in this file.
// TESTING
//  1 Reset, then pop -> ReturnAddress=0, underflow_err=1, occupancy=0; reset again -> underflow_err=0.
//  2 Push with PC=0x100, then push with PC=0x200 -> ReturnAddress=0x204, occupancy=2.
//    Pop -> ReturnAddress=0x104. Pop -> ReturnAddress=0, stack_empty=1.
//  3 Fill DEPTH=16 with PC=0x0,0x10..0xF0 -> stack_full=1, ReturnAddress=0xF4.
//    17th push with PC=0x500 -> dropped, overflow_err=1, ReturnAddress=0xF4.
//  4 Occupancy 3, top=0x304; push+pop with PC=0x800.
//    Before the edge ReturnAddress=0x304; after it ReturnAddress=0x804, occupancy=3.
//  5 Push with PC=0xFFFFFFFC -> ReturnAddress=0x00000000, occupancy=1, stack_empty=0 (wrap).
//  6 Occupancy 4; assert reset together with push -> occupancy=0, ReturnAddress=0, no entry written.
//    Pop next cycle -> underflow_err=1.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
// Shared PC-path definitions: PC source select codes, default return stack depth and link offset.
// Also holds the per-edge operation codes used by the return address stack.
package return_address_stack_pkg;

    typedef enum logic [1:0] {
        PC_SRC_DFT = 2'b00,
        PC_SRC_RA  = 2'b01,
        PC_SRC_BTA = 2'b10,
        PC_SRC_JMP = 2'b11
    } pc_src_e;

    localparam int unsigned RAS_DEPTH = 16;
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    // Resolved stack operation for one clock edge.
    typedef enum logic [2:0] {
        RAS_OP_HOLD    = 3'd0,
        RAS_OP_PUSH    = 3'd1,
        RAS_OP_POP     = 3'd2,
        RAS_OP_REPLACE = 3'd3,
        RAS_OP_DROP    = 3'd4
    } ras_op_e;

endpackage

// File: rtl/return_address_stack.sv
// Hardware call/return stack feeding ReturnAddress to the PC register stage.
// Top of stack is held in a register so the output path never goes through the entry array.
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int unsigned DEPTH  = RAS_DEPTH,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sig_push,
    input  logic              sig_pop,
    input  logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] ReturnAddress,
    output logic              stack_empty,
    output logic              stack_full,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] top_q;
    logic [CNT_W-1:0]  sp_q;
    logic              overflow_q;
    logic              underflow_q;

    logic [ADDR_W-1:0] link_addr;
    logic [IDX_W-1:0]  sp_lo;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic              set_overflow;
    logic              set_underflow;
    ras_op_e           op;

    assign link_addr = PC + ADDR_W'(LINK_OFFSET);
    assign is_empty  = (sp_q == '0);
    assign is_full   = (sp_q == CNT_W'(DEPTH));
    // Low pointer bits index modulo DEPTH, so sp-1 and sp-2 stay correct when sp == DEPTH.
    assign sp_lo     = sp_q[IDX_W-1:0];
    assign rd_idx    = sp_lo - IDX_W'(2);

    always_comb begin
        op            = RAS_OP_HOLD;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = sp_lo;
        if (sig_push && sig_pop) begin
            if (is_empty) begin
                op            = RAS_OP_PUSH;
                set_underflow = 1'b1;
                wr_en         = 1'b1;
            end else begin
                op     = RAS_OP_REPLACE;
                wr_en  = 1'b1;
                wr_idx = sp_lo - IDX_W'(1);
            end
        end else if (sig_push) begin
            if (is_full) begin
                op           = RAS_OP_DROP;
                set_overflow = 1'b1;
            end else begin
                op    = RAS_OP_PUSH;
                wr_en = 1'b1;
            end
        end else if (sig_pop) begin
            if (is_empty) begin
                set_underflow = 1'b1;
            end else begin
                op = RAS_OP_POP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q        <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case (op)
                RAS_OP_PUSH: begin
                    sp_q  <= sp_q + CNT_W'(1);
                    top_q <= link_addr;
                end
                RAS_OP_REPLACE: top_q <= link_addr;
                RAS_OP_POP: begin
                    sp_q  <= sp_q - CNT_W'(1);
                    top_q <= (sp_q >= CNT_W'(2)) ? mem[rd_idx] : '0;
                end
                default: ;
            endcase
            if (set_overflow) overflow_q <= 1'b1;
            if (set_underflow) underflow_q <= 1'b1;
        end
    end

    // Entry array is deliberately not reset; reset still blocks a same-cycle write.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= link_addr;
        end
    end

    assign ReturnAddress = top_q;
    assign occupancy     = sp_q;
    assign stack_empty   = is_empty;
    assign stack_full    = is_full;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule
